hilo_md_ctrl: RTL and testbench
===============================

HILO_MD_CTRL -- requirements
Module: hilo_md_ctrl

Interface
REQ-001 SHALL have clk, input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1 bit, synchronous, active-high; clock clk.
REQ-003 SHALL have start, input, 1 bit, request from E stage to issue a HI/LO operation this cycle.
REQ-004 SHALL have op, input, 3 bits, operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op.
REQ-005 SHALL have rs, input, 32 bits, first operand (dividend / multiplicand / MT source).
REQ-006 SHALL have rt, input, 32 bits, second operand (divisor / multiplier).
REQ-007 SHALL have cancel, input, 1 bit, interrupt/exception flush of the E-stage instruction.
REQ-008 SHALL have busy, output, 1 bit, high while a multiply/divide is in flight; D-stage stall source for HI/LO instructions.
REQ-009 SHALL have hi, output, 32 bits, architectural HI register.
REQ-010 SHALL have lo, output, 32 bits, architectural LO register.

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, plus a 4-bit down-counter cnt.
REQ-012 SHALL accept a request only when state==IDLE, start==1, cancel==0 at the rising edge; otherwise start is ignored with no state change.
REQ-013 SHALL on accepted mult/multu: latch 64-bit signed/unsigned product rs*rt into internal result, load cnt=5, go to MUL.
REQ-014 SHALL on accepted div/divu: latch quotient/remainder into internal result, load cnt=10, go to DIV.
REQ-015 SHALL on accepted mthi/mtlo: write rs to hi/lo at that same edge, stay IDLE, busy stays 0.
REQ-016 SHALL decrement cnt each edge in MUL/DIV; at the edge where cnt==1, write result to hi/lo and return to IDLE.
REQ-017 SHALL assert busy combinationally as (state!=IDLE), i.e. exactly 5 cycles for mult and 10 cycles for div after the accepting edge.
REQ-018 SHALL update hi/lo only at the completion edge or an MT edge; hi/lo hold previous values while busy.
REQ-019 SHALL for mult/multu set hi=product[63:32], lo=product[31:0].
REQ-020 SHALL for div signed: quotient truncated toward zero into lo, remainder with dividend's sign into hi; divu unsigned.
REQ-021 SHALL for div 0x80000000 / 0xFFFFFFFF give lo=0x80000000, hi=0x00000000.
REQ-022 SHALL for divisor==0 run the full 10 cycles and leave hi/lo unchanged.
REQ-023 SHALL ignore start (any op, including MT) while busy; upstream stall guarantees this does not occur, behaviour still defined.
REQ-024 SHALL not abort an in-flight operation on cancel; cancel only suppresses acceptance in the cycle it is high.
REQ-025 SHALL treat op 6/7 with start as no-op: no state, hi, lo change.

Reset
REQ-026 SHALL on reset edge set state=IDLE, cnt=0, hi=0, lo=0, busy=0, internal result=0.
REQ-027 SHALL give reset priority over start, cancel and completion, including reset mid-operation (result discarded).

Verification
REQ-028 mult rs=0xFFFFFFFF rt=2 start at edge T -> busy=1 for edges T..T+5, at T+5 hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-029 div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu rs=7 rt=0 -> hi/lo unchanged after 10 cycles.
REQ-030 mthi rs=0x12345678 -> hi=0x12345678 next edge, busy never 1; mtlo with cancel=1 -> lo unchanged.
REQ-031 mult in flight, cnt=3, start div and cancel pulses -> ignored; mult result written at original completion edge.
REQ-032 reset asserted in cycle 4 of div -> next edge busy=0, hi=lo=0; completion never writes.
REQ-033 back-to-back: mult completes at edge E, div start at edge E+1 accepted -> busy low exactly one cycle between.

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide controller: latches the product or quotient/remainder at issue,
// then models a fixed 5-cycle (mult) or 10-cycle (div) latency before committing to HI/LO.
module hilo_md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        wr_q, wr_d;

    logic        signed_op;
    logic        accept;
    logic [63:0] rs_ext, rt_ext, product;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag, div_den;
    logic [31:0] uquo, urem, quo, rem;

    // Arithmetic datapath; signed division works on magnitudes so INT_MIN / -1 wraps cleanly.
    always_comb begin
        signed_op = ~op[0];
        rs_ext    = {{32{signed_op & rs[31]}}, rs};
        rt_ext    = {{32{signed_op & rt[31]}}, rt};
        product   = rs_ext * rt_ext;
        rs_neg    = signed_op & rs[31];
        rt_neg    = signed_op & rt[31];
        rs_mag    = rs_neg ? (32'd0 - rs) : rs;
        rt_mag    = rt_neg ? (32'd0 - rt) : rt;
        div_den   = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        uquo      = rs_mag / div_den;
        urem      = rs_mag % div_den;
        quo       = (rs_neg ^ rt_neg) ? (32'd0 - uquo) : uquo;
        rem       = rs_neg ? (32'd0 - urem) : urem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        wr_d     = wr_q;
        accept   = start && !cancel && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            res_hi_d = product[63:32];
                            res_lo_d = product[31:0];
                            wr_d     = 1'b1;
                            cnt_d    = 4'd5;
                            state_d  = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor still takes the full latency but commits nothing.
                            if (rt != 32'd0) begin
                                res_hi_d = rem;
                                res_lo_d = quo;
                                wr_d     = 1'b1;
                            end else begin
                                wr_d     = 1'b0;
                            end
                            cnt_d    = 4'd10;
                            state_d  = DIV;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    if (wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            wr_q     <= wr_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed testbench for hilo_md_ctrl: hand-computed HI/LO results, busy timing,
// cancel/ignore behaviour, reset mid-operation and back-to-back issue.
module tb_hilo_md_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    hilo_md_ctrl dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs     (rs),
        .rt     (rt),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic c);
        start  = 1'b1;
        op     = o;
        rs     = a;
        rt     = b;
        cancel = c;
        tick();
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    // Issue one mult/div, check busy and held HI/LO for every in-flight cycle, then the result.
    task automatic run_md(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(o, a, b, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy cycle %0d: got %b expected 1", name, i, busy);
            end
            vectors++;
            if (hi !== model_hi || lo !== model_lo) begin
                miscompares++;
                $display("FAIL %s hold cycle %0d: got hi=%h lo=%h expected hi=%h lo=%h",
                         name, i, hi, lo, model_hi, model_lo);
            end
            tick();
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy at completion: got %b expected 0", name, busy);
        end
        vectors++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h",
                     name, hi, lo, exp_hi, exp_lo);
        end
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        op    = 3'd4;
        rs    = 32'hDEAD_BEEF;
        tick();
        start = 1'b0;
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_mult();
        run_md("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_md("div_neg",   3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_zero", 3'd3, 32'd7, 32'd0, 10, model_hi, model_lo);
        run_md("div_negdiv", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_md("divu",      3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        run_md("div_ovf",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    endtask

    task automatic test_mt();
        issue(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        model_hi = 32'h1234_5678;
        vectors++;
        if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            miscompares++;
            $display("FAIL mthi: got busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, model_hi, model_lo);
        end
        issue(3'd5, 32'hAAAA_5555, 32'd0, 1'b1);
        vectors++;
        if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            miscompares++;
            $display("FAIL mtlo_cancel: got busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, model_hi, model_lo);
        end
        for (int o = 6; o < 8; o++) begin
            issue(3'(o), 32'h5A5A_5A5A, 32'h0000_0003, 1'b0);
            vectors++;
            if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
                miscompares++;
                $display("FAIL nop op%0d: got busy=%b hi=%h lo=%h expected 0 %h %h", o, busy, hi, lo, model_hi, model_lo);
            end
        end
        issue(3'd5, 32'h0BAD_F00D, 32'd0, 1'b0);
        model_lo = 32'h0BAD_F00D;
        vectors++;
        if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            miscompares++;
            $display("FAIL mtlo: got busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, model_hi, model_lo);
        end
    endtask

    task automatic test_ignore_while_busy();
        issue(3'd0, 32'd3, 32'd5, 1'b0);
        tick();
        tick();
        start = 1'b1; op = 3'd2; rs = 32'd100; rt = 32'd7; cancel = 1'b1;
        tick();
        start = 1'b1; op = 3'd5; rs = 32'h0000_FFFF; cancel = 1'b0;
        tick();
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || hi !== model_hi || lo !== model_lo) begin
            miscompares++;
            $display("FAIL ignore_hold: got busy=%b hi=%h lo=%h expected 1 %h %h", busy, hi, lo, model_hi, model_lo);
        end
        tick();
        model_hi = 32'd0;
        model_lo = 32'd15;
        vectors++;
        if (busy !== 1'b0 || hi !== model_hi || lo !== model_lo) begin
            miscompares++;
            $display("FAIL ignore_done: got busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, model_hi, model_lo);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || lo !== model_lo) begin
            miscompares++;
            $display("FAIL ignore_after: got busy=%b lo=%h expected 0 %h", busy, lo, model_lo);
        end
    endtask

    task automatic test_reset_mid_div();
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_discard: got busy=%b hi=%h lo=%h expected 0/0/0", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        run_md("b2b_mult", 3'd0, 32'd2, 32'd3, 5, 32'd0, 32'd6);
        run_md("b2b_div",  3'd3, 32'd20, 32'd6, 10, 32'd2, 32'd3);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        rs     = 32'd0;
        rt     = 32'd0;
        cancel = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_ignore_while_busy();
        test_reset_mid_div();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
